// File: rtl/key_sel_gen.sv
// Two debounced active-low push-buttons step a wrapping 3-bit select up/down.
// The select drives decoder3_8 inputs in1..in3; sel_chg pulses with each new value.
module key_sel_gen #(
  parameter int         CNT_MAX  = 1_000_000,
  parameter logic [2:0] SEL_INIT = 3'd0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_up,
  input  logic key_down,
  output logic in1,
  output logic in2,
  output logic in3,
  output logic sel_chg
);

  localparam int            CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(CNT_MAX - 2);

  // Bit 0 carries the up key, bit 1 the down key throughout.
  logic [1:0]    key_raw;
  logic [1:0]    key_m;
  logic [1:0]    key_s;
  logic [CW-1:0] cnt [2];
  logic [1:0]    press;
  logic [2:0]    sel;

  assign key_raw = {key_down, key_up};

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      key_m <= 2'b11;
      key_s <= 2'b11;
    end else begin
      key_m <= key_raw;
      key_s <= key_m;
    end
  end

  // The press flag fires only on the step into saturation, so a held key
  // yields one pulse and a release is needed before the next one.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!sys_rst_n) begin
        cnt[i]   <= '0;
        press[i] <= 1'b0;
      end else begin
        press[i] <= !key_s[i] && (cnt[i] == CNT_PRE);
        if (key_s[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] < CNT_TOP) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Simultaneous up and down flags cancel out.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sel     <= SEL_INIT;
      sel_chg <= 1'b0;
    end else begin
      sel_chg <= 1'b0;
      case (press)
        2'b01: begin
          sel     <= sel + 3'd1;
          sel_chg <= 1'b1;
        end
        2'b10: begin
          sel     <= sel - 3'd1;
          sel_chg <= 1'b1;
        end
        default: sel <= sel;
      endcase
    end
  end

  assign in1 = sel[2];
  assign in2 = sel[1];
  assign in3 = sel[0];

endmodule

// File: tb/tb_key_sel_gen.sv
// Directed bench for key_sel_gen: each expected step is queued with its value and
// edge number; a negedge monitor pops on every sel_chg and also enforces holds.
module tb_key_sel_gen;

  localparam int         CNT_MAX  = 20;
  localparam logic [2:0] SEL_INIT = 3'd0;

  typedef struct {
    logic [2:0] sel;
    int         edge_no;
  } exp_t;

  logic clk;
  logic rst_n;
  logic key_up;
  logic key_down;
  logic in1;
  logic in2;
  logic in3;
  logic sel_chg;

  exp_t       exp_q[$];
  int         edge_cnt = 0;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 0;
  logic [2:0] model_sel = SEL_INIT;
  logic [2:0] prev_sel = SEL_INIT;

  key_sel_gen #(.CNT_MAX(CNT_MAX), .SEL_INIT(SEL_INIT)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key_up   (key_up),
    .key_down (key_down),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .sel_chg  (sel_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt++;

  // Monitor: reset values while reset is low, queued step on every sel_chg,
  // and an unchanged select on every other cycle.
  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t       e;
    if (mon_en) begin
      cur = {in1, in2, in3};
      total++;
      if (rst_n !== 1'b1) begin
        if (cur !== SEL_INIT || sel_chg !== 1'b0) begin
          bad++;
          $display("[TB] FAIL reset_state edge=%0d sel=%b chg=%b required sel=%b chg=0",
                   edge_cnt, cur, sel_chg, SEL_INIT);
        end
      end else if (sel_chg === 1'b1) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_step edge=%0d sel=%b required no sel_chg", edge_cnt, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.sel || edge_cnt != e.edge_no) begin
            bad++;
            $display("[TB] FAIL step sel=%b at edge %0d required sel=%b at edge %0d",
                     cur, edge_cnt, e.sel, e.edge_no);
          end
        end
      end else if (cur !== prev_sel || sel_chg !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold edge=%0d sel=%b chg=%b required sel=%b chg=0",
                 edge_cnt, cur, sel_chg, prev_sel);
      end
      prev_sel = cur;
    end
  end

  task automatic check_queue_empty(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s pending=%0d required pending=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_sel = SEL_INIT;
    repeat (cycles) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Key goes low just after a negedge, so the next posedge is E0.
  task automatic apply_press(input bit up, input int low_cycles, input bit expect_step);
    exp_t e;
    @(negedge clk);
    #1;
    if (expect_step) begin
      model_sel = up ? model_sel + 3'd1 : model_sel - 3'd1;
      e.sel     = model_sel;
      e.edge_no = edge_cnt + 1 + CNT_MAX + 1;
      exp_q.push_back(e);
    end
    if (up) key_up = 1'b0;
    else key_down = 1'b0;
    repeat (low_cycles) @(negedge clk);
    #1;
    key_up   = 1'b1;
    key_down = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic drive_up(input logic level, input int cycles);
    #1 key_up = level;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int   m;
    exp_t e;
    rst_n    = 1'b0;
    key_up   = 1'b1;
    key_down = 1'b1;

    // Reset held 5 cycles, then 100 idle cycles with no change
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(negedge clk);

    // Clean up press held 40 cycles: 001 at E21
    apply_press(1'b1, 40, 1'b1);
    check_queue_empty("clean_press");

    // Wrap-around: eight ups from 000 then one down
    apply_reset(2);
    for (int i = 0; i < 8; i++) apply_press(1'b1, 25, 1'b1);
    apply_press(1'b0, 25, 1'b1);
    check_queue_empty("wrap");

    // Bounce rejection followed by one valid press
    apply_reset(2);
    @(negedge clk);
    drive_up(1'b0, 10);
    drive_up(1'b1, 2);
    drive_up(1'b0, 10);
    drive_up(1'b1, 3);
    drive_up(1'b0, 15);
    drive_up(1'b1, 25);
    apply_press(1'b1, 25, 1'b1);
    check_queue_empty("bounce");

    // Simultaneous press cancels, then a lone down press
    apply_reset(2);
    @(negedge clk);
    #1;
    key_up   = 1'b0;
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    key_up   = 1'b1;
    key_down = 1'b1;
    repeat (10) @(negedge clk);
    apply_press(1'b0, 25, 1'b1);
    check_queue_empty("simultaneous");

    // Reset mid-debounce at cnt=15; step only after a fresh full debounce
    @(negedge clk);
    #1 key_up = 1'b0;
    m = edge_cnt;
    repeat (16) @(negedge clk);
    #1 rst_n = 1'b0;
    model_sel = SEL_INIT;
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_sel = model_sel + 3'd1;
    e.sel     = model_sel;
    e.edge_no = m + 18 + CNT_MAX + 1;
    exp_q.push_back(e);
    repeat (35) @(negedge clk);
    #1 key_up = 1'b1;
    repeat (10) @(negedge clk);
    check_queue_empty("reset_mid_op");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_sel_gen.md
# key_sel_gen

Upstream stage for the `decoder3_8` block: turns two active-low push-buttons into the 3-bit select that drives the decoder's `in1`/`in2`/`in3` inputs. Each key is synchronised and debounced, and each accepted press steps a wrapping 3-bit select counter up or down. A one-cycle change strobe is also produced for downstream logic.

## Interface
Parameters:
- `CNT_MAX`, default 1_000_000: debounce length in clock cycles (20 ms at 50 MHz); legal range ≥ 4.
- `SEL_INIT`, default 3'd0: select value loaded at reset.

Ports:
- `sys_clk` input 1: system clock, 50 MHz; all logic is on its rising edge.
- `sys_rst_n` input 1: reset, synchronous, active-low.
- `key_up` input 1: asynchronous push-button, low = pressed; increments select.
- `key_down` input 1: asynchronous push-button, low = pressed; decrements select.
- `in1` output 1: select bit 2 (MSB), registered.
- `in2` output 1: select bit 1, registered.
- `in3` output 1: select bit 0 (LSB), registered.
- `sel_chg` output 1: one-cycle pulse in the cycle the new select value first appears on `in1..in3`.

## Operation
- Reset: while `sys_rst_n` is sampled low, the following values are loaded.
  - `{in1,in2,in3}` = SEL_INIT.
  - `sel_chg` = 0.
  - Both synchroniser stages = 1 (released).
  - Both debounce counters = 0.
  - Both press flags = 0.
- A reset asserted mid-debounce or mid-update aborts the operation. No step and no `sel_chg` is produced from the aborted press.
- Per key, a 2-FF synchroniser produces `key_s`.
- Per key, the debounce counter `cnt` (width = clog2(CNT_MAX)) behaves as follows:
  - `key_s` = 1: `cnt` ← 0.
  - `key_s` = 0 and `cnt` < CNT_MAX-1: `cnt` ← `cnt`+1.
  - `key_s` = 0 and `cnt` = CNT_MAX-1: `cnt` holds (saturates).
- Press flag: a registered signal, high for exactly one cycle, at the edge where `cnt` transitions CNT_MAX-2 → CNT_MAX-1.
  - One step per physical press.
  - Holding the key never auto-repeats.
  - A new press requires a release first (`key_s` = 1 for ≥ 1 cycle clears `cnt`).
- Bounce: any high glitch on `key_s` restarts `cnt` from 0. A low pulse shorter than CNT_MAX-1 synchronised cycles produces no step.
- Select update: at the edge after a press flag, according to the flags present.
  - `up` only: sel ← sel+1 mod 8 (7 → 0).
  - `down` only: sel ← sel-1 mod 8 (0 → 7).
  - Both flags in the same cycle: no change and no `sel_chg`.
  - Neither flag: hold.
- `sel_chg` is registered and high in the cycle the new value is visible, i.e. it asserts together with the `in1..in3` update.
- Outputs change only on an accepted step. They are glitch-free because they are driven directly from flops.

## Timing
- Let E0 be the first rising edge that samples a key low, with the key held low thereafter.
  - E1: `key_s` = 0.
  - E(k+1): `cnt` = k.
  - E(CNT_MAX): `cnt` = CNT_MAX-1 and the press flag goes high.
  - E(CNT_MAX+1): `in1..in3` updated, `sel_chg` = 1.
  - E(CNT_MAX+2): `sel_chg` = 0.
- Latency key → select: CNT_MAX+1 edges.
- Throughput: at most one step per key per press. The minimum press-to-press interval is 1 release cycle + CNT_MAX+1.
- Presses on the two keys that mature on different cycles each produce their own step, in order.

## Test plan
All scenarios run with CNT_MAX = 20 and SEL_INIT = 0.
- Reset: hold `sys_rst_n` = 0 for 5 cycles with both keys = 1. Require `{in1,in2,in3}` = 000 and `sel_chg` = 0 during and after reset. Release reset; outputs hold for 100 cycles.
- Clean up-press: drive `key_up` = 0 sampled at E0 and held for 40 cycles, then release. Require `{in1,in2,in3}` = 001 and `sel_chg` = 1 exactly at E21. `sel_chg` = 0 at E22, and no further change while held.
- Wrap-around: apply 8 clean `key_up` presses. Require the sequence 001, 010 … 111, 000 with 8 `sel_chg` pulses. Then 1 `key_down` press from 000 gives 111.
- Bounce rejection: drive `key_up` low 10 cycles, high 2 cycles, low 10 cycles, high 3 cycles, low 15 cycles, then high. Require no change and no `sel_chg`. A following 25-cycle low press gives exactly one step.
- Simultaneous press: drop both keys low at the same edge and hold for 30 cycles. Require no select change and no `sel_chg`. Then press `key_down` alone from 000 and require 111.
- Reset mid-operation: start a `key_up` press and assert `sys_rst_n` = 0 at `cnt` = 15 for 1 cycle while the key stays low. Require select = 000 with no step from that press. The step occurs only 21 edges after the first post-reset edge that samples the key low, i.e. a full fresh debounce.
